// File: rtl/conv2d_tile_host.sv
// Host-side sequencer for the 3x3 convolution engine: loads kernel and image words
// into scratchpads B/A, handshakes with the engine, then streams results out of C.
module conv2d_tile_host #(
    parameter int MAX_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic [7:0]        base_a,
    input  logic [7:0]        base_b,
    input  logic [7:0]        base_c,
    input  logic [4:0]        tile_w,
    input  logic [4:0]        tile_h,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              a_en,
    output logic              a_we,
    output logic [7:0]        a_addr,
    output logic [DATA_W-1:0] a_di,
    output logic              b_en,
    output logic              b_we,
    output logic [7:0]        b_addr,
    output logic [DATA_W-1:0] b_di,
    output logic              c_en,
    output logic              c_we,
    output logic [7:0]        c_addr,
    input  logic [DATA_W-1:0] c_dout,
    output logic              eng_start,
    input  logic              eng_done
);
    typedef enum logic [2:0] {IDLE, LOAD_B, LOAD_A, RUN, RELEASE, DRAIN, DONE} state_t;
    localparam logic [4:0] MAX_DIM = 5'(MAX_W);

    state_t            state, state_nxt;
    logic [7:0]        cfg_a, cfg_b, cfg_c;
    logic [4:0]        cfg_w, cfg_h;
    logic              err_q;
    logic [7:0]        load_cnt, area_m1, n_out, n_m1;
    logic [7:0]        rem, rd_idx, pop_idx;
    logic              armed, rd_vld_p1;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              rptr, wptr;
    logic [1:0]        fifo_cnt;
    logic              cfg_ok, beat, last_b, last_a, push, pop;

    assign cfg_ok  = (tile_w >= 5'd3) && (tile_w <= MAX_DIM) &&
                     (tile_h >= 5'd3) && (tile_h <= MAX_DIM);
    // A 16x16 tile has 256 words; the 8-bit product wraps to 0 so area-1 is still 255.
    assign area_m1 = {3'd0, cfg_w} * {3'd0, cfg_h} - 8'd1;
    assign n_out   = {3'd0, cfg_w - 5'd2} * {3'd0, cfg_h - 5'd2};
    assign n_m1    = n_out - 8'd1;
    assign beat    = in_valid && in_ready;
    assign last_b  = (load_cnt == 8'd8);
    assign last_a  = (load_cnt == area_m1);
    assign push    = rd_vld_p1;
    assign pop     = out_valid && out_ready;

    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = fifo_mem[rptr];
    assign out_last  = out_valid && (pop_idx == n_m1);
    assign c_we      = 1'b0;
    assign c_addr    = cfg_c + rd_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = cfg_ok ? LOAD_B : DONE;
            LOAD_B:  if (beat && last_b) state_nxt = LOAD_A;
            LOAD_A:  if (beat && last_a) state_nxt = RUN;
            RUN:     if (eng_done) state_nxt = RELEASE;
            RELEASE: if (!eng_done) state_nxt = DRAIN;
            DRAIN:   if (pop && (pop_idx == n_m1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One read can be in flight; the FIFO always has room for it when it lands.
    always_comb begin
        in_ready  = 1'b0;
        eng_start = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        c_en      = 1'b0;
        case (state)
            LOAD_B, LOAD_A: in_ready = 1'b1;
            RUN:            eng_start = 1'b1;
            DRAIN:          c_en = armed && (rem != 8'd0) &&
                                   (({1'b0, fifo_cnt} + {2'b00, rd_vld_p1} - {2'b00, pop}) < 3'd2);
            DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            err_q     <= 1'b0;
            cfg_a     <= '0;
            cfg_b     <= '0;
            cfg_c     <= '0;
            cfg_w     <= '0;
            cfg_h     <= '0;
            load_cnt  <= '0;
            armed     <= 1'b0;
            rem       <= '0;
            rd_idx    <= '0;
            pop_idx   <= '0;
            rd_vld_p1 <= 1'b0;
            rptr      <= 1'b0;
            wptr      <= 1'b0;
            fifo_cnt  <= '0;
        end else begin
            if (state == IDLE && go) begin
                err_q   <= !cfg_ok;
                busy    <= cfg_ok;
                cfg_a   <= base_a;
                cfg_b   <= base_b;
                cfg_c   <= base_c;
                cfg_w   <= tile_w;
                cfg_h   <= tile_h;
                rd_idx  <= '0;
                pop_idx <= '0;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end

            if (state == IDLE)  load_cnt <= '0;
            else if (beat)      load_cnt <= (state == LOAD_B && last_b) ? 8'd0 : load_cnt + 8'd1;

            // First DRAIN cycle arms the read counter; reads start on the second.
            if (state == DRAIN) begin
                if (!armed) begin
                    armed <= 1'b1;
                    rem   <= n_out;
                end else if (c_en) begin
                    rem <= rem - 8'd1;
                end
            end else begin
                armed <= 1'b0;
            end

            if (c_en) rd_idx  <= rd_idx + 8'd1;
            if (pop)  pop_idx <= pop_idx + 8'd1;
            rd_vld_p1 <= c_en;

            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else if (push) begin
            fifo_mem[wptr] <= c_dout;
        end
    end

    // Write ports: accepted beat in cycle t appears on the scratchpad port in t+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_en   <= 1'b0;
            a_we   <= 1'b0;
            a_addr <= '0;
            a_di   <= '0;
            b_en   <= 1'b0;
            b_we   <= 1'b0;
            b_addr <= '0;
            b_di   <= '0;
        end else begin
            a_en <= (state == LOAD_A) && beat;
            a_we <= (state == LOAD_A) && beat;
            b_en <= (state == LOAD_B) && beat;
            b_we <= (state == LOAD_B) && beat;
            if (state == LOAD_A && beat) begin
                a_addr <= cfg_a + load_cnt;
                a_di   <= in_data;
            end
            if (state == LOAD_B && beat) begin
                b_addr <= cfg_b + load_cnt;
                b_di   <= in_data;
            end
        end
    end
endmodule

// File: tb/tb_conv2d_tile_host.sv
// Directed bench for conv2d_tile_host with behavioural scratchpads A/B/C and a
// behavioural 3x3 engine attached to the scratchpad and engine ports.
`timescale 1ns/1ps
module tb_conv2d_tile_host;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go = 1'b0;
    logic [7:0]  base_a = '0, base_b = '0, base_c = '0;
    logic [4:0]  tile_w = '0, tile_h = '0;
    logic        busy, done, err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid, out_last;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        a_en, a_we, b_en, b_we, c_en, c_we;
    logic [7:0]  a_addr, b_addr, c_addr;
    logic [31:0] a_di, b_di;
    logic [31:0] c_dout = '0;
    logic        eng_start;
    logic        eng_done = 1'b0;

    conv2d_tile_host dut (
        .clk(clk), .reset_n(reset_n), .go(go),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .tile_w(tile_w), .tile_h(tile_h),
        .busy(busy), .done(done), .err(err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_di(a_di),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_di(b_di),
        .c_en(c_en), .c_we(c_we), .c_addr(c_addr), .c_dout(c_dout),
        .eng_start(eng_start), .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural scratchpads and engine.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] mem_c [256];
    int job_ba, job_bb, job_bc, job_w, job_h;
    logic [3:0] eng_timer = '0;

    always @(posedge clk) begin
        if (a_en && a_we) mem_a[a_addr] <= a_di;
        if (b_en && b_we) mem_b[b_addr] <= b_di;
        if (c_en) c_dout <= mem_c[c_addr];
    end

    task automatic run_engine;
        int idx = 0;
        logic [31:0] acc;
        for (int r = 0; r < job_h - 2; r++)
            for (int c = 0; c < job_w - 2; c++) begin
                acc = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc = acc + mem_a[8'(job_ba + (r + i) * job_w + c + j)] * mem_b[8'(job_bb + i * 3 + j)];
                mem_c[8'(job_bc + idx)] = acc;
                idx++;
            end
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            eng_done  <= 1'b0;
            eng_timer <= '0;
        end else if (eng_done) begin
            if (!eng_start) eng_done <= 1'b0;
        end else if (eng_start) begin
            if (eng_timer == 4'd3) begin
                run_engine();
                eng_done  <= 1'b1;
                eng_timer <= '0;
            end else begin
                eng_timer <= eng_timer + 4'd1;
            end
        end else begin
            eng_timer <= '0;
        end
    end

    // Output-side flow control, changed just after each rising edge.
    logic rand_ready = 1'b0;
    logic hold_ready = 1'b0;
    always @(posedge clk) begin
        #2;
        if (hold_ready)      out_ready = 1'b0;
        else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        else                 out_ready = 1'b1;
    end

    // Observation logs, sampled on the falling edge.
    int          beat_cyc[$];
    logic [7:0]  bw_addr[$];
    int          bw_cyc[$];
    logic [7:0]  aw_addr[$];
    int          aw_cyc[$];
    logic [31:0] aw_data[$];
    logic [31:0] out_q[$];
    logic        last_q[$];
    int          hs_cyc[$];
    logic [31:0] exp_q[$];
    logic [31:0] stim_q[$];
    int          done_cyc = -1;
    logic        done_err = 1'b0;
    logic        done_seen = 1'b0;
    int          activity = 0;

    always @(negedge clk) begin
        if (in_valid && in_ready) beat_cyc.push_back(cyc);
        if (b_en && b_we) begin
            bw_addr.push_back(b_addr);
            bw_cyc.push_back(cyc);
        end
        if (a_en && a_we) begin
            aw_addr.push_back(a_addr);
            aw_cyc.push_back(cyc);
            aw_data.push_back(a_di);
        end
        if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            last_q.push_back(out_last);
            hs_cyc.push_back(cyc);
        end
        if (done) begin
            done_cyc  = cyc;
            done_err  = err;
            done_seen = 1'b1;
        end
        if (a_en || b_en || c_en || eng_start) activity++;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_ctl"}, 32'({busy, done, err, in_ready, out_valid, out_last, a_en, a_we,
                                  b_en, b_we, c_en, c_we, eng_start}), 32'd0);
        check({pfx, "_addr"}, {8'd0, a_addr, b_addr, c_addr}, 32'd0);
        check({pfx, "_data"}, a_di | b_di | out_data, 32'd0);
    endtask

    task automatic clear_logs;
        beat_cyc.delete(); bw_addr.delete(); bw_cyc.delete();
        aw_addr.delete(); aw_cyc.delete(); aw_data.delete();
        out_q.delete(); last_q.delete(); hs_cyc.delete();
        done_seen = 1'b0;
        done_cyc  = -1;
        activity  = 0;
    endtask

    task automatic start_job(input int bb, input int ba, input int bc, input int w, input int h);
        job_bb = bb; job_ba = ba; job_bc = bc; job_w = w; job_h = h;
        @(posedge clk); #1;
        base_b = 8'(bb); base_a = 8'(ba); base_c = 8'(bc);
        tile_w = 5'(w);  tile_h = 5'(h);
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic feed(input int n, input bit throttle);
        int  idx = 0;
        int  guard = 0;
        bit  tog = 1'b1;
        bit  beat;
        while (idx < n && guard < 2000) begin
            in_valid = throttle ? tog : 1'b1;
            tog      = !tog;
            in_data  = stim_q[idx];
            @(negedge clk);
            beat = in_valid && in_ready;
            @(posedge clk); #1;
            if (beat) idx++;
            guard++;
        end
        in_valid = 1'b0;
        check("feed_words_taken", 32'(idx), 32'(n));
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done_seen && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("done_seen", 32'(done_seen), 32'd1);
    endtask

    task automatic check_outputs(input string pfx);
        logic [31:0] lm = '0;
        int last_hs;
        check({pfx, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check({pfx, "_word"}, (i < out_q.size()) ? out_q[i] : 32'hDEAD_BEEF, exp_q[i]);
        for (int i = 0; i < last_q.size() && i < 32; i++) lm[i] = last_q[i];
        check({pfx, "_last_mask"}, lm, 32'd1 << (exp_q.size() - 1));
        last_hs = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size() - 1] : -100;
        check({pfx, "_done_after_last"}, 32'(done_cyc), 32'(last_hs + 1));
        check({pfx, "_err"}, 32'(done_err), 32'd0);
    endtask

    task automatic build_identity;
        stim_q.delete();
        for (int i = 0; i < 9; i++)  stim_q.push_back(32'd1);
        for (int i = 0; i < 16; i++) stim_q.push_back(32'(i));
        exp_q.delete();
        exp_q.push_back(32'd45); exp_q.push_back(32'd54);
        exp_q.push_back(32'd81); exp_q.push_back(32'd90);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Identity flow with write-port timing
        build_identity();
        clear_logs();
        start_job(8'h10, 8'h20, 8'h40, 4, 4);
        check("busy_after_go", 32'(busy), 32'd1);
        feed(25, 1'b0);
        wait_done(300);
        check_outputs("identity");
        check("identity_throughput", 32'(hs_cyc.size() >= 4 ? hs_cyc[3] - hs_cyc[0] : -1), 32'd3);
        check("b_write_count", 32'(bw_addr.size()), 32'd9);
        check("a_write_count", 32'(aw_addr.size()), 32'd16);
        for (int i = 0; i < 9; i++) begin
            check("b_addr", (i < bw_addr.size()) ? 32'(bw_addr[i]) : 32'hDEAD_BEEF, 32'h10 + 32'(i));
            check("b_write_lag", (i < bw_cyc.size()) ? 32'(bw_cyc[i]) : 32'hDEAD_BEEF,
                  (i < beat_cyc.size()) ? 32'(beat_cyc[i] + 1) : 32'hFFFF_FFFF);
        end
        for (int i = 0; i < 16; i++) begin
            check("a_addr", (i < aw_addr.size()) ? 32'(aw_addr[i]) : 32'hDEAD_BEEF, 32'h20 + 32'(i));
            check("a_data", (i < aw_data.size()) ? aw_data[i] : 32'hDEAD_BEEF, 32'(i));
            check("a_write_lag", (i < aw_cyc.size()) ? 32'(aw_cyc[i]) : 32'hDEAD_BEEF,
                  (9 + i < beat_cyc.size()) ? 32'(beat_cyc[9 + i] + 1) : 32'hFFFF_FFFF);
        end
        @(posedge clk); #1;
        check("busy_after_done", 32'(busy), 32'd0);

        // Stream throttling on both sides
        build_identity();
        clear_logs();
        rand_ready = 1'b1;
        start_job(8'h00, 8'h60, 8'hA0, 4, 4);
        feed(25, 1'b1);
        wait_done(600);
        check_outputs("throttled");
        rand_ready = 1'b0;
        @(posedge clk); #1;

        // Error path: width too small, then height too large
        clear_logs();
        in_valid = 1'b1;
        start_job(8'h10, 8'h20, 8'h40, 2, 4);
        check("err_done", 32'(done), 32'd1);
        check("err_flag", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("err_done_pulse", 32'(done), 32'd0);
        start_job(8'h10, 8'h20, 8'h40, 4, 17);
        check("err_h17_done_err", 32'({done, err}), 32'd3);
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("err_no_port_activity", 32'(activity), 32'd0);

        // Address wrap on scratchpad A
        build_identity();
        clear_logs();
        start_job(8'h30, 8'hF8, 8'h80, 4, 4);
        feed(25, 1'b0);
        wait_done(300);
        check_outputs("wrap");
        for (int i = 0; i < 16; i++)
            check("wrap_a_addr", (i < aw_addr.size()) ? 32'(aw_addr[i]) : 32'hDEAD_BEEF,
                  32'((8'hF8 + 8'(i)) & 8'hFF));
        @(posedge clk); #1;

        // Reset in LOAD_A: the write of the final accepted beat is squashed
        build_identity();
        clear_logs();
        start_job(8'h10, 8'h20, 8'h40, 4, 4);
        feed(14, 1'b0);
        check("load_a_write_pending", 32'(a_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check_zero("reset_load_a");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset in DRAIN with the output FIFO backed up
        build_identity();
        clear_logs();
        hold_ready = 1'b1;
        start_job(8'h10, 8'h20, 8'h40, 4, 4);
        feed(25, 1'b0);
        begin
            int k = 0;
            while (!out_valid && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        check("drain_reached", 32'(out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_zero("reset_drain");
        hold_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Fresh 3x3 job after reset: kernel 0..8, image all 2 -> 2*36 = 72
        stim_q.delete();
        for (int i = 0; i < 9; i++) stim_q.push_back(32'(i));
        for (int i = 0; i < 9; i++) stim_q.push_back(32'd2);
        exp_q.delete();
        exp_q.push_back(32'd72);
        clear_logs();
        start_job(8'h00, 8'h30, 8'h50, 3, 3);
        feed(18, 1'b0);
        wait_done(300);
        check_outputs("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
